// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit pipeline: widths, instruction field
// positions, opcode constants and the decoded-instruction record.
package isa_pkg;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;
  localparam int IMM_W  = 5;
  localparam int NREG   = 8;
  localparam int REG_AW = $clog2(NREG);
  localparam int BOFF_W = 11;

  localparam int OPC_MSB      = 15;
  localparam int OPC_LSB      = 12;
  localparam int IMM_FLAG_BIT = 11;
  localparam int RD_MSB       = 10;
  localparam int RD_LSB       = 8;
  localparam int RS1_MSB      = 7;
  localparam int RS1_LSB      = 5;
  localparam int RS2_MSB      = 4;
  localparam int RS2_LSB      = 2;
  localparam int IMM_MSB      = 4;
  localparam int IMM_LSB      = 0;
  localparam int BOFF_MSB     = 10;
  localparam int BOFF_LSB     = 0;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_BR0 = 4'hC;
  localparam logic [OPC_W-1:0] OP_BR1 = 4'hD;
  localparam logic [OPC_W-1:0] OP_BR2 = 4'hE;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [IMM_W-1:0]  imm;
    logic              imm_flag;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] branch_target;
  } decoded_t;

  function automatic logic is_branch(input logic [OPC_W-1:0] opc);
    return (opc == OP_BR0) || (opc == OP_BR1) || (opc == OP_BR2);
  endfunction

endpackage

// File: rtl/regfile_ro.sv
// Read-only 8x16 register file: every entry is loaded with its own index on
// reset and never written otherwise. Two combinational read ports.
module regfile_ro
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NREG];

  // No write port: contents only change when reset reloads R[i] = i.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/instr_decode_unit.sv
// Single-issue decode stage: extracts fields, reads operands, sign-extends
// the immediate, detects branches and registers the result with stall/flush.
module instr_decode_unit
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              is_branch_taken,
  input  logic [DATA_W-1:0] instr,
  output logic [OPC_W-1:0]  opcode,
  output logic [IMM_W-1:0]  imm,
  output logic              imm_flag,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] branch_target
);

  // Handshake: there is no valid/ready pair. The stage captures instr on every
  // rising edge unless stall holds it; is_branch_taken loads a NOP bubble and
  // overrides stall. Outputs are valid one edge after instr is sampled.

  logic [OPC_W-1:0]  f_opc;
  logic              f_imm_flag;
  logic [REG_AW-1:0] f_rs1;
  logic [REG_AW-1:0] f_rs2;
  logic [IMM_W-1:0]  f_imm5;
  logic [BOFF_W-1:0] f_boff;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  decoded_t          dec;
  decoded_t          q;

  assign f_opc      = instr[OPC_MSB:OPC_LSB];
  assign f_imm_flag = instr[IMM_FLAG_BIT];
  assign f_rs1      = instr[RS1_MSB:RS1_LSB];
  assign f_rs2      = instr[RS2_MSB:RS2_LSB];
  assign f_imm5     = instr[IMM_MSB:IMM_LSB];
  assign f_boff     = instr[BOFF_MSB:BOFF_LSB];

  regfile_ro u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (f_rs1),
    .raddr2 (f_rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    dec = '0;
    if (f_opc != OP_NOP) begin
      dec.opcode   = f_opc;
      dec.imm_flag = f_imm_flag;
      dec.op1      = rs1_val;
      if (f_imm_flag) begin
        dec.imm = f_imm5;
        dec.op2 = {{(DATA_W - IMM_W){f_imm5[IMM_W-1]}}, f_imm5};
      end else begin
        dec.op2 = rs2_val;
      end
      if (is_branch(f_opc)) begin
        dec.branch_target = {{(DATA_W - BOFF_W){1'b0}}, f_boff};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (is_branch_taken) begin
      q <= '0;
    end else if (!stall) begin
      q <= dec;
    end
  end

  assign opcode        = q.opcode;
  assign imm           = q.imm;
  assign imm_flag      = q.imm_flag;
  assign op1           = q.op1;
  assign op2           = q.op2;
  assign branch_target = q.branch_target;

endmodule

// File: tb/tb_instr_decode_unit.sv
// Directed bench for instr_decode_unit: stimulus pushes hand-computed expected
// outputs into a queue, a monitor pops and compares after each edge.
module tb_instr_decode_unit;

  localparam int W = 4 + 5 + 1 + 16 + 16 + 16;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        is_branch_taken;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [4:0]  imm;
  logic        imm_flag;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [15:0] branch_target;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           errors;
  bit           stim_done;

  instr_decode_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .is_branch_taken (is_branch_taken),
    .instr           (instr),
    .opcode          (opcode),
    .imm             (imm),
    .imm_flag        (imm_flag),
    .op1             (op1),
    .op2             (op2),
    .branch_target   (branch_target)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] pack(input logic [3:0] o, input logic [4:0] i,
                                        input logic f, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] t);
    return {o, i, f, a, b, t};
  endfunction

  function automatic logic [W-1:0] actual();
    return {opcode, imm, imm_flag, op1, op2, branch_target};
  endfunction

  task automatic check(input string name, input logic [W-1:0] exp_v);
    logic [W-1:0] got;
    got = actual();
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got opc=%h imm=%h flg=%b op1=%h op2=%h bt=%h, expected opc=%h imm=%h flg=%b op1=%h op2=%h bt=%h",
               name, got[57:54], got[53:49], got[48], got[47:32], got[31:16], got[15:0],
               exp_v[57:54], exp_v[53:49], exp_v[48], exp_v[47:32], exp_v[31:16], exp_v[15:0]);
    end
  endtask

  // Driver: set inputs away from the edge, queue the expected result of the next edge
  task automatic step(input string name, input logic [15:0] ins, input logic stl,
                      input logic fl, input logic [W-1:0] exp_v);
    @(negedge clk);
    instr           = ins;
    stall           = stl;
    is_branch_taken = fl;
    exp_q.push_back(exp_v);
    name_q.push_back(name);
    @(posedge clk);
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] e;
    string        n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, e);
      end
    end
  end

  logic [W-1:0] zero_v;
  logic [W-1:0] v2294;
  logic [W-1:0] vfcb7;
  logic [W-1:0] vde60;
  logic [W-1:0] v3a51;

  initial begin
    checks = 0;
    errors = 0;
    stim_done = 0;
    zero_v = '0;
    v2294 = pack(4'h2, 5'h00, 1'b0, 16'h0004, 16'h0005, 16'h0000);
    vfcb7 = pack(4'hF, 5'h17, 1'b1, 16'h0005, 16'hFFF7, 16'h0000);
    vde60 = pack(4'hD, 5'h00, 1'b1, 16'h0003, 16'h0000, 16'h0660);
    v3a51 = pack(4'h3, 5'h11, 1'b1, 16'h0002, 16'hFFF1, 16'h0000);

    reset = 1'b1;
    stall = 1'b0;
    is_branch_taken = 1'b0;
    instr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_initial", zero_v);
    @(negedge clk);
    reset = 1'b0;

    step("reg_form_2294", 16'h2294, 1'b0, 1'b0, v2294);
    step("imm_form_fcb7", 16'hFCB7, 1'b0, 1'b0, vfcb7);
    step("branch_de60", 16'hDE60, 1'b0, 1'b0, vde60);
    step("nop_0fff", 16'h0FFF, 1'b0, 1'b0, zero_v);
    step("branch_c123", 16'hC123, 1'b0, 1'b0,
         pack(4'hC, 5'h00, 1'b0, 16'h0001, 16'h0000, 16'h0123));
    step("branch_e7ff", 16'hE7FF, 1'b0, 1'b0,
         pack(4'hE, 5'h00, 1'b0, 16'h0007, 16'h0007, 16'h07FF));
    step("nonbranch_b7ff", 16'hB7FF, 1'b0, 1'b0,
         pack(4'hB, 5'h00, 1'b0, 16'h0007, 16'h0007, 16'h0000));
    step("imm_pos_180f", 16'h180F, 1'b0, 1'b0,
         pack(4'h1, 5'h0F, 1'b1, 16'h0000, 16'h000F, 16'h0000));

    // Flush, plain and with stall also high
    step("pre_flush", 16'hDE60, 1'b0, 1'b0, vde60);
    step("flush", 16'hDE60, 1'b0, 1'b1, zero_v);
    step("post_flush", 16'hDE60, 1'b0, 1'b0, vde60);
    step("flush_with_stall", 16'hDE60, 1'b1, 1'b1, zero_v);
    step("stall_after_flush", 16'hDE60, 1'b1, 1'b0, zero_v);
    step("post_flush2", 16'hDE60, 1'b0, 1'b0, vde60);

    // Stall holds previous outputs, release decodes current instr
    step("pre_stall", 16'h2294, 1'b0, 1'b0, v2294);
    step("stall_1", 16'h3A51, 1'b1, 1'b0, v2294);
    step("stall_2", 16'h3A51, 1'b1, 1'b0, v2294);
    step("stall_release", 16'h3A51, 1'b0, 1'b0, v3a51);

    // Asynchronous reset mid-cycle, during a stall
    step("pre_reset", 16'hFCB7, 1'b0, 1'b0, vfcb7);
    @(negedge clk);
    stall = 1'b1;
    instr = 16'h2294;
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", zero_v);
    @(posedge clk);
    #1;
    check("reset_held_edge", zero_v);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    #1;
    check("reset_released_pre_edge", zero_v);
    step("after_reset", 16'h2294, 1'b0, 1'b0, v2294);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    stim_done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
